// File: rtl/mask_encoder_if.sv
// mask_encoder_if: output word stream of the mask encoder.
//   out_wr    : word valid, held until accepted
//   out_dout  : packed word, first byte in [7:0], second byte in [15:8]
//   out_ready : sink accepts the word in a cycle where out_wr is high
// master = encoder side, slave = sink side.
interface mask_encoder_if;
  logic        out_wr;
  logic [15:0] out_dout;
  logic        out_ready;

  modport master (output out_wr, output out_dout, input out_ready);
  modport slave  (input out_wr, input out_dout, output out_ready);
endinterface

// File: rtl/mask_encoder.sv
// mask_encoder: run-length encoder for raster-ordered segment maps.
// Horizontal runs of one segment id become 40-bit records
// {length[39:30], y[29:20], start_x[19:10], id[9:0]}, which are buffered in a
// small FIFO and serialized LSB byte first into 16-bit words.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pixel_valid, video_x/y     pixel strobe and coordinates
//   pixel_has_segment/_id      segment membership and id of the pixel
//   frame_end                  closes the open run and flushes the output
//   out_bus (master)           out_wr / out_dout / out_ready word stream
//   record_count               records accepted into the FIFO (saturating)
//   overflow                   sticky: a record was dropped on a full FIFO
//   busy                       any work still in flight
module mask_encoder #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_LENGTH = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pixel_valid,
  input  logic [9:0]            video_x,
  input  logic [9:0]            video_y,
  input  logic                  pixel_has_segment,
  input  logic [9:0]            pixel_segment_id,
  input  logic                  frame_end,
  mask_encoder_if.master        out_bus,
  output logic [14:0]           record_count,
  output logic                  overflow,
  output logic                  busy
);
  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [9:0] MAX_LEN  = 10'(MAX_LENGTH);

  // run tracker
  logic        run_open_q, run_open_d;
  logic [9:0]  run_id_q, run_id_d, run_y_q, run_y_d;
  logic [9:0]  run_start_x_q, run_start_x_d, run_last_x_q, run_last_x_d;
  logic [9:0]  run_len_q, run_len_d;
  logic [9:0]  next_x;
  logic        extend;

  // closed records waiting one cycle for the FIFO; a pixel and a frame_end in
  // the same cycle can close two runs at once, hence two slots
  logic        rec_a_vld_q, rec_a_vld_d, rec_b_vld_q, rec_b_vld_d;
  logic [39:0] rec_a_q, rec_a_d, rec_b_q, rec_b_d;

  // record FIFO
  logic [39:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt_ptr, wa_b;
  logic [AW:0]   count_q, count_d, count_after_a;
  logic          push_a, push_b, pop;
  logic [39:0]   head;
  logic [7:0]    nxt_byte0;

  // serializer / output
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        out_wr_q, out_wr_d;
  logic [15:0] out_dout_q, out_dout_d;
  logic        flush_q, flush_d;
  logic        last_byte, have_word, pad_word;
  logic [7:0]  b0, b1;
  logic [14:0] record_count_q, record_count_d;
  logic [15:0] rc_sum;
  logic        overflow_q, overflow_d;

  function automatic logic [7:0] rec_byte(input logic [39:0] r, input logic [2:0] i);
    case (i)
      3'd0:    return r[7:0];
      3'd1:    return r[15:8];
      3'd2:    return r[23:16];
      3'd3:    return r[31:24];
      default: return r[39:32];
    endcase
  endfunction

  // 10-bit wrap is intentional: x=1023 followed by x=0 continues a run
  assign next_x = run_last_x_q + 10'd1;

  always_comb begin
    run_open_d    = run_open_q;
    run_id_d      = run_id_q;
    run_y_d       = run_y_q;
    run_start_x_d = run_start_x_q;
    run_last_x_d  = run_last_x_q;
    run_len_d     = run_len_q;
    rec_a_vld_d   = 1'b0;
    rec_a_d       = rec_a_q;
    rec_b_vld_d   = 1'b0;
    rec_b_d       = rec_b_q;
    extend        = 1'b0;
    if (pixel_valid) begin
      if (pixel_has_segment) begin
        extend = run_open_q && (pixel_segment_id == run_id_q) && (video_y == run_y_q) &&
                 (video_x == next_x) && (run_len_q < MAX_LEN);
        if (extend) begin
          run_last_x_d = video_x;
          run_len_d    = run_len_q + 10'd1;
        end else begin
          if (run_open_q) begin
            rec_a_vld_d = 1'b1;
            rec_a_d     = {run_len_q, run_y_q, run_start_x_q, run_id_q};
          end
          run_open_d    = 1'b1;
          run_id_d      = pixel_segment_id;
          run_y_d       = video_y;
          run_start_x_d = video_x;
          run_last_x_d  = video_x;
          run_len_d     = 10'd1;
        end
      end else if (run_open_q) begin
        rec_a_vld_d = 1'b1;
        rec_a_d     = {run_len_q, run_y_q, run_start_x_q, run_id_q};
        run_open_d  = 1'b0;
      end
    end
    // frame_end acts after the pixel of the same cycle
    if (frame_end && run_open_d) begin
      rec_b_vld_d = 1'b1;
      rec_b_d     = {run_len_d, run_y_d, run_start_x_d, run_id_d};
      run_open_d  = 1'b0;
    end
  end

  // FIFO push side; full is judged on the registered count, so a pop in the
  // same cycle does not make room for a push
  assign push_a        = rec_a_vld_q && (count_q < DEPTH_C);
  assign count_after_a = count_q + (AW+1)'(push_a);
  assign push_b        = rec_b_vld_q && (count_after_a < DEPTH_C);
  assign wa_b          = wr_ptr_q + AW'(push_a);
  assign rd_nxt_ptr    = rd_ptr_q + AW'(1);
  assign head          = fifo_mem[rd_ptr_q];
  assign nxt_byte0     = fifo_mem[rd_nxt_ptr][7:0];

  always_ff @(posedge clk) begin
    if (push_a) fifo_mem[wr_ptr_q] <= rec_a_q;
    if (push_b) fifo_mem[wa_b]     <= rec_b_q;
  end

  // Serializer reads bytes straight out of the FIFO head and pops a record
  // only when its last byte enters the output word, so a stalled sink leaves
  // the record occupying its FIFO entry.
  always_comb begin
    out_wr_d   = out_wr_q;
    out_dout_d = out_dout_q;
    byte_idx_d = byte_idx_q;
    pop        = 1'b0;
    b0         = rec_byte(head, byte_idx_q);
    b1         = 8'h00;
    last_byte  = (byte_idx_q == 3'd4);
    have_word  = (count_q >= (AW+1)'(2)) || ((count_q == (AW+1)'(1)) && !last_byte);
    // lone trailing byte is padded only once nothing else can follow it
    pad_word   = (count_q == (AW+1)'(1)) && last_byte && flush_q && !rec_a_vld_q && !rec_b_vld_q;
    if (out_wr_q && out_bus.out_ready) out_wr_d = 1'b0;
    if ((!out_wr_q || out_bus.out_ready) && (have_word || pad_word)) begin
      out_wr_d = 1'b1;
      if (!last_byte) begin
        b1 = rec_byte(head, byte_idx_q + 3'd1);
        if (byte_idx_q == 3'd3) begin
          pop        = 1'b1;
          byte_idx_d = 3'd0;
        end else begin
          byte_idx_d = byte_idx_q + 3'd2;
        end
      end else begin
        pop = 1'b1;
        if (pad_word) begin
          b1         = 8'h00;
          byte_idx_d = 3'd0;
        end else begin
          b1         = nxt_byte0;
          byte_idx_d = 3'd1;
        end
      end
      out_dout_d = {b1, b0};
    end
  end

  always_comb begin
    count_d        = count_q + (AW+1)'(push_a) + (AW+1)'(push_b) - (AW+1)'(pop);
    wr_ptr_d       = wr_ptr_q + AW'(push_a) + AW'(push_b);
    rd_ptr_d       = rd_ptr_q + AW'(pop);
    rc_sum         = {1'b0, record_count_q} + 16'(push_a) + 16'(push_b);
    record_count_d = (rc_sum > 16'h7FFF) ? 15'h7FFF : rc_sum[14:0];
    overflow_d     = overflow_q | (rec_a_vld_q & ~push_a) | (rec_b_vld_q & ~push_b);
    flush_d        = frame_end | (flush_q & ((count_q != '0) | rec_a_vld_q | rec_b_vld_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_open_q     <= 1'b0;
      run_id_q       <= '0;
      run_y_q        <= '0;
      run_start_x_q  <= '0;
      run_last_x_q   <= '0;
      run_len_q      <= '0;
      rec_a_vld_q    <= 1'b0;
      rec_a_q        <= '0;
      rec_b_vld_q    <= 1'b0;
      rec_b_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      byte_idx_q     <= '0;
      out_wr_q       <= 1'b0;
      out_dout_q     <= '0;
      flush_q        <= 1'b0;
      record_count_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      run_open_q     <= run_open_d;
      run_id_q       <= run_id_d;
      run_y_q        <= run_y_d;
      run_start_x_q  <= run_start_x_d;
      run_last_x_q   <= run_last_x_d;
      run_len_q      <= run_len_d;
      rec_a_vld_q    <= rec_a_vld_d;
      rec_a_q        <= rec_a_d;
      rec_b_vld_q    <= rec_b_vld_d;
      rec_b_q        <= rec_b_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      byte_idx_q     <= byte_idx_d;
      out_wr_q       <= out_wr_d;
      out_dout_q     <= out_dout_d;
      flush_q        <= flush_d;
      record_count_q <= record_count_d;
      overflow_q     <= overflow_d;
    end
  end

  assign out_bus.out_wr   = out_wr_q;
  assign out_bus.out_dout = out_dout_q;
  assign record_count     = record_count_q;
  assign overflow         = overflow_q;
  assign busy             = run_open_q | rec_a_vld_q | rec_b_vld_q | (count_q != '0) |
                            out_wr_q | flush_q;
endmodule

// File: tb/tb_mask_encoder.sv
// tb_mask_encoder: self-checking bench for mask_encoder.
// dut uses FIFO_DEPTH=16 and is checked through a byte scoreboard; dut2 uses
// FIFO_DEPTH=2 for the drop/overflow case.
module tb_mask_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pixel_valid, pixel_has_segment, frame_end;
  logic [9:0]  video_x, video_y, pixel_segment_id;
  logic [14:0] record_count;
  logic        overflow, busy;
  mask_encoder_if ob();

  logic        p2_valid, p2_has, p2_fe;
  logic [9:0]  p2_x, p2_y, p2_id;
  logic [14:0] rc2;
  logic        ovf2, busy2;
  mask_encoder_if ob2();

  mask_encoder #(.FIFO_DEPTH(16), .MAX_LENGTH(1023)) dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .video_x(video_x), .video_y(video_y),
    .pixel_has_segment(pixel_has_segment), .pixel_segment_id(pixel_segment_id),
    .frame_end(frame_end), .out_bus(ob), .record_count(record_count),
    .overflow(overflow), .busy(busy));

  mask_encoder #(.FIFO_DEPTH(2), .MAX_LENGTH(1023)) dut2 (
    .clk(clk), .reset(reset), .pixel_valid(p2_valid), .video_x(p2_x), .video_y(p2_y),
    .pixel_has_segment(p2_has), .pixel_segment_id(p2_id),
    .frame_end(p2_fe), .out_bus(ob2), .record_count(rc2),
    .overflow(ovf2), .busy(busy2));

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_bytes[$];
  int         exp_total = 0;
  int         exp_cnt   = 0;

  typedef struct {
    logic [9:0]  id;
    logic [9:0]  y;
    logic [9:0]  x0;
    int          len;
    bit          fe_with_last;
    logic [39:0] rec;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [9:0] x, input logic [9:0] y, input logic [9:0] id,
                    input logic has, input logic fe);
    pixel_valid = 1'b1; video_x = x; video_y = y;
    pixel_has_segment = has; pixel_segment_id = id; frame_end = fe;
    tick();
    pixel_valid = 1'b0; frame_end = 1'b0;
  endtask

  task automatic fend();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic push_rec(input logic [39:0] r);
    for (int b = 0; b < 5; b++) exp_bytes.push_back(r[8*b +: 8]);
    exp_total += 5;
    exp_cnt++;
  endtask

  task automatic exp_flush();
    if (exp_total % 2 == 1) begin
      exp_bytes.push_back(8'h00);
      exp_total++;
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    @(negedge clk);
    while ((busy || exp_bytes.size() != 0) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({name, "_left"}, 64'(exp_bytes.size()), 0);
    check({name, "_busy"}, 64'(busy), 0);
    check({name, "_count"}, 64'(record_count), 64'(exp_cnt));
  endtask

  // scoreboard and hold-stability monitor for dut
  logic        rdy_at_edge = 1'b0, rst_at_edge = 1'b1;
  logic        prev_wr = 1'b0;
  logic [15:0] prev_dout = '0;
  always @(posedge clk) begin
    rdy_at_edge = ob.out_ready;
    rst_at_edge = reset;
  end
  always @(negedge clk) begin
    logic [15:0] e;
    if (prev_wr && !rdy_at_edge && !rst_at_edge) begin
      n_checks++;
      if (!(ob.out_wr && ob.out_dout == prev_dout)) begin
        n_fail++;
        $display("FAIL hold: got wr=%0d dout=%h required wr=1 dout=%h", ob.out_wr, ob.out_dout, prev_dout);
      end
    end
    if (!reset && ob.out_wr && ob.out_ready) begin
      n_checks++;
      if (exp_bytes.size() < 2) begin
        n_fail++;
        $display("FAIL word: got unexpected %h with %0d bytes expected", ob.out_dout, exp_bytes.size());
      end else begin
        e = {exp_bytes[1], exp_bytes[0]};
        void'(exp_bytes.pop_front());
        void'(exp_bytes.pop_front());
        $display("word %h expected %h", ob.out_dout, e);
        if (ob.out_dout !== e) begin
          n_fail++;
          $display("FAIL word: got %h expected %h", ob.out_dout, e);
        end
      end
    end
    prev_wr   = ob.out_wr;
    prev_dout = ob.out_dout;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] ra, rb, r2a, r2b;
    logic [7:0]  ob2_exp[$];
    logic [15:0] e2;
    int          got, extra, c;

    vecs[0] = '{id: 10'd5,   y: 10'd3,    x0: 10'd10,   len: 4,  fe_with_last: 1'b0, rec: 40'h01_0030_2805};
    vecs[1] = '{id: 10'h3FF, y: 10'h3FF,  x0: 10'h3FF,  len: 1,  fe_with_last: 1'b1, rec: 40'h00_7FFF_FFFF};
    vecs[2] = '{id: 10'd0,   y: 10'd0,    x0: 10'd0,    len: 2,  fe_with_last: 1'b0, rec: 40'h00_8000_0000};
    vecs[3] = '{id: 10'h2AA, y: 10'h155,  x0: 10'd100,  len: 20, fe_with_last: 1'b1, rec: 40'h05_1551_92AA};

    reset = 1'b1; pixel_valid = 1'b0; pixel_has_segment = 1'b0; frame_end = 1'b0;
    video_x = '0; video_y = '0; pixel_segment_id = '0;
    p2_valid = 1'b0; p2_has = 1'b0; p2_fe = 1'b0; p2_x = '0; p2_y = '0; p2_id = '0;
    ob.out_ready = 1'b1; ob2.out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_wr", 64'(ob.out_wr), 0);
    check("rst_dout", 64'(ob.out_dout), 0);
    check("rst_count", 64'(record_count), 0);
    check("rst_ovf", 64'(overflow), 0);
    check("rst_busy", 64'(busy), 0);
    reset = 1'b0;
    tick();

    // single-run table
    for (int i = 0; i < 4; i++) begin
      push_rec(vecs[i].rec);
      exp_flush();
      for (int k = 0; k < vecs[i].len; k++)
        px(vecs[i].x0 + 10'(k), vecs[i].y, vecs[i].id, 1'b1,
           vecs[i].fe_with_last && (k == vecs[i].len - 1));
      if (!vecs[i].fe_with_last) fend();
      wait_idle("vec");
      $display("vec %0d rec %h count %0d", i, vecs[i].rec, record_count);
    end

    // adjacent ids on one row
    push_rec({10'd2, 10'd0, 10'd0, 10'd1});
    push_rec({10'd1, 10'd0, 10'd2, 10'd2});
    exp_flush();
    px(10'd0, 10'd0, 10'd1, 1'b1, 1'b0);
    px(10'd1, 10'd0, 10'd1, 1'b1, 1'b0);
    px(10'd2, 10'd0, 10'd2, 1'b1, 1'b0);
    fend();
    wait_idle("adjacent");
    $display("adjacent count %0d", record_count);

    // 1030 pixels, x wraps after 1023: split at MAX_LENGTH
    push_rec({10'd1023, 10'd2, 10'd0, 10'd7});
    push_rec({10'd7, 10'd2, 10'd1023, 10'd7});
    exp_flush();
    for (int i = 0; i < 1030; i++) px(10'(i), 10'd2, 10'd7, 1'b1, 1'b0);
    fend();
    wait_idle("split");
    $display("split count %0d", record_count);

    // row change with contiguous x splits the run
    push_rec({10'd4, 10'd5, 10'd0, 10'd9});
    push_rec({10'd2, 10'd6, 10'd4, 10'd9});
    exp_flush();
    for (int i = 0; i < 4; i++) px(10'(i), 10'd5, 10'd9, 1'b1, 1'b0);
    px(10'd4, 10'd6, 10'd9, 1'b1, 1'b0);
    px(10'd5, 10'd6, 10'd9, 1'b1, 1'b1);
    wait_idle("ychange");
    $display("ychange count %0d", record_count);

    // backpressure: three records while the sink stalls
    ob.out_ready = 1'b0;
    push_rec({10'd2, 10'd8, 10'd0, 10'd3});
    push_rec({10'd3, 10'd8, 10'd5, 10'd4});
    push_rec({10'd1, 10'd8, 10'd20, 10'd5});
    exp_flush();
    px(10'd0, 10'd8, 10'd3, 1'b1, 1'b0);
    px(10'd1, 10'd8, 10'd3, 1'b1, 1'b0);
    px(10'd5, 10'd8, 10'd4, 1'b1, 1'b0);
    px(10'd6, 10'd8, 10'd4, 1'b1, 1'b0);
    px(10'd7, 10'd8, 10'd4, 1'b1, 1'b0);
    px(10'd20, 10'd8, 10'd5, 1'b1, 1'b1);
    repeat (50) tick();
    @(negedge clk);
    check("bp_held_wr", 64'(ob.out_wr), 1);
    check("bp_busy", 64'(busy), 1);
    tick();
    ob.out_ready = 1'b1;
    wait_idle("backpressure");
    $display("backpressure count %0d", record_count);

    // reset while a word is held
    ob.out_ready = 1'b0;
    px(10'd0, 10'd1, 10'd11, 1'b1, 1'b0);
    px(10'd1, 10'd1, 10'd11, 1'b1, 1'b0);
    px(10'd2, 10'd1, 10'd11, 1'b1, 1'b1);
    c = 0;
    @(negedge clk);
    while (!ob.out_wr && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("rstmid_wr_before", 64'(ob.out_wr), 1);
    #1 reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_wr", 64'(ob.out_wr), 0);
    check("rstmid_busy", 64'(busy), 0);
    check("rstmid_count", 64'(record_count), 0);
    exp_bytes.delete();
    exp_total = 0;
    exp_cnt = 0;
    tick();
    ob.out_ready = 1'b1;
    push_rec({10'd3, 10'd1, 10'd7, 10'd12});
    exp_flush();
    px(10'd7, 10'd1, 10'd12, 1'b1, 1'b0);
    px(10'd8, 10'd1, 10'd12, 1'b1, 1'b0);
    px(10'd9, 10'd1, 10'd12, 1'b1, 1'b1);
    wait_idle("after_reset");
    check("main_ovf", 64'(overflow), 0);
    $display("after reset count %0d", record_count);

    // overflow on the 2-entry FIFO with the sink stalled
    r2a = {10'd1, 10'd0, 10'd0, 10'd1};
    r2b = {10'd1, 10'd0, 10'd2, 10'd2};
    for (int b = 0; b < 5; b++) ob2_exp.push_back(r2a[8*b +: 8]);
    for (int b = 0; b < 5; b++) ob2_exp.push_back(r2b[8*b +: 8]);
    for (int i = 0; i < 4; i++) begin
      p2_valid = 1'b1; p2_has = 1'b1; p2_x = 10'(2 * i); p2_y = 10'd0; p2_id = 10'(i + 1);
      p2_fe = (i == 3);
      tick();
    end
    p2_valid = 1'b0; p2_fe = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("ovf_flag", 64'(ovf2), 1);
    check("ovf_count", 64'(rc2), 2);
    tick();
    ob2.out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 100 && got < 5; k++) begin
      @(negedge clk);
      if (ob2.out_wr && ob2.out_ready) begin
        e2 = {ob2_exp[1], ob2_exp[0]};
        void'(ob2_exp.pop_front());
        void'(ob2_exp.pop_front());
        $display("ovf word %h expected %h", ob2.out_dout, e2);
        check("ovf_word", 64'(ob2.out_dout), 64'(e2));
        got++;
      end
    end
    check("ovf_words", 64'(got), 5);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (ob2.out_wr) extra++;
    end
    check("ovf_extra", 64'(extra), 0);
    check("ovf_busy", 64'(busy2), 0);
    check("ovf_sticky", 64'(ovf2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
